// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: load-use stall, jump/branch flush and multi-cycle mul/div hold.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_Rs,
    input  logic [4:0]        IFID_Rt,
    input  logic              ID_UsesRt,
    input  logic              ID_Jump,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_WriteReg,
    input  logic              EX_BranchTaken,
    input  logic              EX_MulDiv,
    output logic              PCWrite,
    output logic [1:0]        IFID_cond,
    output logic [1:0]        IDEX_cond,
    output logic              EXMEM_bubble,
    output logic              MD_done,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    localparam logic [1:0] C_FLUSH = 2'd0;
    localparam logic [1:0] C_PASS  = 2'd1;
    localparam logic [1:0] C_HOLD  = 2'd2;

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic       low_pc;
    logic [1:0] low_ifid;
    logic [1:0] low_idex;

    // Lower-priority rules shared by RUN and the mul/div exit cycle.
    always_comb begin
        load_use = IDEX_MemRead && (IDEX_WriteReg != 5'd0) &&
                   ((IDEX_WriteReg == IFID_Rs) ||
                    (ID_UsesRt && (IDEX_WriteReg == IFID_Rt)));
        low_pc   = 1'b1;
        low_ifid = C_PASS;
        low_idex = C_PASS;
        if (load_use) begin
            low_pc   = 1'b0;
            low_ifid = C_HOLD;
            low_idex = C_FLUSH;
        end else if (ID_Jump) begin
            low_ifid = C_FLUSH;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCWrite      = low_pc;
        IFID_cond    = low_ifid;
        IDEX_cond    = low_idex;
        EXMEM_bubble = 1'b0;
        MD_done      = 1'b0;
        if (reset) begin
            PCWrite      = 1'b0;
            IFID_cond    = C_FLUSH;
            IDEX_cond    = C_FLUSH;
            EXMEM_bubble = 1'b1;
        end else if (state_q == RUN) begin
            if (EX_BranchTaken) begin
                PCWrite   = 1'b1;
                IFID_cond = C_FLUSH;
                IDEX_cond = C_FLUSH;
            end else if (EX_MulDiv) begin
                PCWrite      = 1'b0;
                IFID_cond    = C_HOLD;
                IDEX_cond    = C_HOLD;
                EXMEM_bubble = 1'b1;
                cnt_d        = CNT_W'(MD_LAT - 2);
                state_d      = MD_BUSY;
            end
        end else if (cnt_q != '0) begin
            PCWrite      = 1'b0;
            IFID_cond    = C_HOLD;
            IDEX_cond    = C_HOLD;
            EXMEM_bubble = 1'b1;
            cnt_d        = cnt_q - 1'b1;
        end else begin
            // Exit cycle: EX_MulDiv is ignored so the finishing op cannot restart itself.
            MD_done = 1'b1;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + PERF_W'(!PCWrite);
        flush_d = flush_q + PERF_W'(IFID_cond == C_FLUSH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle model comparison plus literal spot checks.
// Counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs = '0, rt = '0, wreg = '0;
    logic        uses_rt = 0, jump = 0, memread = 0, branch = 0, muldiv = 0;
    logic        pc_write, bubble, md_done;
    logic [1:0]  ifid_cond, idex_cond;
    logic [31:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .IFID_Rs(rs), .IFID_Rt(rt), .ID_UsesRt(uses_rt), .ID_Jump(jump),
        .IDEX_MemRead(memread), .IDEX_WriteReg(wreg),
        .EX_BranchTaken(branch), .EX_MulDiv(muldiv),
        .PCWrite(pc_write), .IFID_cond(ifid_cond), .IDEX_cond(idex_cond),
        .EXMEM_bubble(bubble), .MD_done(md_done),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc;
        logic [1:0] ifid;
        logic [1:0] idex;
        logic       bub;
        logic       done;
    } exp_t;

    // md_idx: which cycle of the current mul/div's EX residency we are in (0 = none active).
    int          md_idx = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_flush = '0;

    function automatic exp_t expect_now(input int idx);
        exp_t e;
        logic lu;
        lu = memread && (wreg != 0) && ((wreg == rs) || (uses_rt && (wreg == rt)));
        e  = '{pc: 1'b1, ifid: 2'd1, idex: 2'd1, bub: 1'b0, done: 1'b0};
        if (reset)
            e = '{pc: 1'b0, ifid: 2'd0, idex: 2'd0, bub: 1'b1, done: 1'b0};
        else if (idx == 0 && branch)
            e = '{pc: 1'b1, ifid: 2'd0, idex: 2'd0, bub: 1'b0, done: 1'b0};
        else if ((idx == 0 && muldiv) || (idx > 0 && idx < MD_LAT))
            e = '{pc: 1'b0, ifid: 2'd2, idex: 2'd2, bub: 1'b1, done: 1'b0};
        else begin
            e.done = (idx == MD_LAT);
            if (lu) begin
                e.pc = 1'b0; e.ifid = 2'd2; e.idex = 2'd0;
            end else if (jump) begin
                e.ifid = 2'd0;
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            md_idx    = 0;
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            e = expect_now(md_idx);
            if (!e.pc) exp_stall = exp_stall + 1;
            if (e.ifid == 2'd0) exp_flush = exp_flush + 1;
            if (md_idx == 0 && !branch && muldiv) md_idx = 2;
            else if (md_idx > 0 && md_idx < MD_LAT) md_idx = md_idx + 1;
            else md_idx = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (check_en) begin
            e = expect_now(md_idx);
            check_output("model.PCWrite", 32'(pc_write), 32'(e.pc));
            check_output("model.IFID_cond", 32'(ifid_cond), 32'(e.ifid));
            check_output("model.IDEX_cond", 32'(idex_cond), 32'(e.idex));
            check_output("model.EXMEM_bubble", 32'(bubble), 32'(e.bub));
            check_output("model.MD_done", 32'(md_done), 32'(e.done));
`ifdef HAZARD_PERF_EN
            check_output("model.stall_cycles", stall_cycles, exp_stall);
            check_output("model.flush_count", flush_count, exp_flush);
`else
            check_output("model.stall_cycles", stall_cycles, 32'd0);
            check_output("model.flush_count", flush_count, 32'd0);
`endif
        end
    end

    task automatic apply_stimulus(input logic mr, input logic [4:0] wr, input logic [4:0] s,
                                  input logic [4:0] t, input logic ur, input logic j,
                                  input logic br, input logic md);
        @(posedge clk);
        #1;
        memread = mr; wreg = wr; rs = s; rt = t; uses_rt = ur; jump = j; branch = br; muldiv = md;
    endtask

    task automatic check_lit(input string name, input logic pc, input logic [1:0] ifid,
                             input logic [1:0] idex, input logic bub, input logic done);
        @(negedge clk);
        check_output({name, ".PCWrite"}, 32'(pc_write), 32'(pc));
        check_output({name, ".IFID"}, 32'(ifid_cond), 32'(ifid));
        check_output({name, ".IDEX"}, 32'(idex_cond), 32'(idex));
        check_output({name, ".bubble"}, 32'(bubble), 32'(bub));
        check_output({name, ".MD_done"}, 32'(md_done), 32'(done));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        memread = 0; wreg = 0; rs = 0; rt = 0; uses_rt = 0; jump = 0; branch = 0; muldiv = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_en = 1;
        check_lit("release", 1, 1, 1, 0, 0);

        // async reset in the middle of a mul/div
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        check_lit("md_start", 0, 2, 2, 1, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst.PCWrite", 32'(pc_write), 32'd0);
        check_output("async_rst.IFID", 32'(ifid_cond), 32'd0);
        check_output("async_rst.IDEX", 32'(idex_cond), 32'd0);
        check_output("async_rst.bubble", 32'(bubble), 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        check_lit("after_rst", 1, 1, 1, 0, 0);

        // branch beats load-use and jump
        apply_stimulus(1, 8, 8, 0, 0, 1, 1, 0);
        check_lit("branch_prio", 1, 0, 0, 0, 0);

        do_reset();
        apply_stimulus(1, 8, 8, 0, 0, 0, 0, 0);
        check_lit("load_use", 0, 2, 0, 0, 0);
        apply_stimulus(0, 8, 8, 0, 0, 0, 0, 0);
        check_lit("lu_next", 1, 1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        check_lit("lu_r0", 1, 1, 1, 0, 0);
        apply_stimulus(1, 8, 3, 8, 0, 0, 0, 0);
        check_lit("lu_rt_unused", 1, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
        check_lit("jump", 1, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_lit("jump_next", 1, 1, 1, 0, 0);
        for (int i = 1; i < MD_LAT; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
            check_lit($sformatf("md_hold%0d", i), 0, 2, 2, 1, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        check_lit("md_exit", 1, 1, 1, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_lit("md_no_retrigger", 1, 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        check_output("perf.stall", stall_cycles, 32'd4);
        check_output("perf.flush", flush_count, 32'd1);
`else
        check_output("perf.stall", stall_cycles, 32'd0);
        check_output("perf.flush", flush_count, 32'd0);
`endif

        apply_stimulus(1, 8, 3, 8, 1, 0, 0, 0);
        check_lit("lu_rt_used", 0, 2, 0, 0, 0);

        // load-use ignored while holding, honoured on the exit cycle
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        check_lit("md2_start", 0, 2, 2, 1, 0);
        for (int i = 2; i < MD_LAT; i++) begin
            apply_stimulus(1, 8, 8, 0, 0, 1, 0, 1);
            check_lit($sformatf("md2_hold%0d", i), 0, 2, 2, 1, 0);
        end
        apply_stimulus(1, 8, 8, 0, 0, 0, 0, 1);
        check_lit("md2_exit_lu", 0, 2, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_lit("md2_after", 1, 1, 1, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
